// File: rtl/ring_sched_pkg.sv
// rtl/ring_sched_pkg.sv - shared types and constants for the ring memory scheduler
//
// Purpose: default geometry, writer index type, grant struct and the
//          round-robin pick function used by rr_arb2.
package ring_sched_pkg;

    localparam int DEF_WIDTH  = 6;
    localparam int DEF_DWIDTH = 8;

    // Index of a write requester (0 or 1).
    typedef logic wr_idx_t;

    typedef struct packed {
        logic gnt0;
        logic gnt1;
    } grant_t;

    // Single-requester wins outright; on contention the writer that did not
    // win last time is chosen. block suppresses every grant.
    function automatic grant_t rr_pick(
        input logic    req0,
        input logic    req1,
        input logic    block,
        input wr_idx_t last
    );
        grant_t g;
        g = '0;
        if (!block) begin
            if (req0 && (!req1 || last == 1'b1)) begin
                g.gnt0 = 1'b1;
            end else if (req1) begin
                g.gnt1 = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ring_mem_sched_rr_arb2.sv
// rtl/ring_mem_sched_rr_arb2.sv - two-input round-robin arbiter
//
// Purpose: grants at most one of two requesters per cycle, alternating under
//          contention, and remembers the last winner.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset (last winner := writer 1)
//   req    in   [1:0] request vector
//   block  in   suppress all grants (ring full)
//   gnt    out  [1:0] one-hot-or-zero grant vector (combinational)
module rr_arb2
    import ring_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] gnt
);

    wr_idx_t last_gnt_q;
    wr_idx_t last_gnt_d;
    grant_t  pick;

    always_comb begin
        pick       = rr_pick(req[0], req[1], block, last_gnt_q);
        gnt        = {pick.gnt1, pick.gnt0};
        last_gnt_d = last_gnt_q;
        if (pick.gnt0) begin
            last_gnt_d = 1'b0;
        end else if (pick.gnt1) begin
            last_gnt_d = 1'b1;
        end
    end

    // Reset to writer 1 so writer 0 wins the first contended cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/ring_mem_sched.sv
// rtl/ring_mem_sched.sv - power-of-two ring memory scheduler with two writers and one reader
//
// Purpose: arbitrates two push requesters into a ring with a per-entry valid
//          bitmap and drains it in order through a 1-cycle registered read port.
// Optional: define RING_SCHED_ASSERT_EN to compile in embedded properties.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   req0     in   writer 0 push request
//   data0    in   [DWIDTH-1:0] writer 0 payload
//   gnt0     out  writer 0 push accepted this cycle
//   req1     in   writer 1 push request
//   data1    in   [DWIDTH-1:0] writer 1 payload
//   gnt1     out  writer 1 push accepted this cycle
//   rd_req   in   consumer pop request
//   rd_vld   out  rd_data valid (registered)
//   rd_data  out  [DWIDTH-1:0] popped word
//   full     out  count == NUM_ELEMS
//   empty    out  count == 0
//   count    out  [WIDTH:0] number of valid entries
module ring_mem_sched
    import ring_sched_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DWIDTH-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DWIDTH-1:0] data1,
    output logic              gnt1,
    input  logic              rd_req,
    output logic              rd_vld,
    output logic [DWIDTH-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [WIDTH:0]    count
);

    localparam int             NUM_ELEMS  = 2 ** WIDTH;
    localparam logic [WIDTH:0] FULL_COUNT = (WIDTH + 1)'(NUM_ELEMS);

    logic [WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [NUM_ELEMS-1:0] valid_q, valid_d;
    logic [WIDTH:0]       count_q, count_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [DWIDTH-1:0]    rd_data_q, rd_data_d;
    logic [DWIDTH-1:0]    mem_q [NUM_ELEMS];

    logic [1:0]           arb_req;
    logic [1:0]           arb_gnt;
    logic                 push;
    logic                 pop;
    logic [DWIDTH-1:0]    push_data;

    // Status comes only from count; wr_ptr == rd_ptr is ambiguous on its own.
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    assign arb_req = {req1, req0};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (arb_req),
        .block (full),
        .gnt   (arb_gnt)
    );

    assign gnt0    = arb_gnt[0];
    assign gnt1    = arb_gnt[1];
    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;

    always_comb begin
        push      = gnt0 | gnt1;
        push_data = gnt1 ? data1 : data0;
        // Pop looks at the registered bitmap, so a same-cycle push into an
        // empty ring is never visible to the pop.
        pop       = rd_req & valid_q[rd_ptr_q];

        wr_ptr_d  = push ? wr_ptr_q + WIDTH'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + WIDTH'(1) : rd_ptr_q;

        // Push and pop can never hit the same slot: a pop needs a valid
        // entry at rd_ptr, and a push needs a free one at wr_ptr.
        valid_d = valid_q;
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase

        rd_vld_d  = pop;
        rd_data_d = pop ? mem_q[rd_ptr_q] : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            valid_q   <= '0;
            count_q   <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

`ifdef RING_SCHED_ASSERT_EN
    logic        init_done_q;
    logic [15:0] push_tag_q, push_tag_d;
    logic [15:0] pop_tag_q, pop_tag_d;
    logic [15:0] tag_mem_q [NUM_ELEMS];

    // Each pushed word carries a free-running tag; pops must see tags in order.
    always_comb begin
        push_tag_d = push ? push_tag_q + 16'd1 : push_tag_q;
        pop_tag_d  = pop  ? pop_tag_q  + 16'd1 : pop_tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done_q <= 1'b0;
            push_tag_q  <= '0;
            pop_tag_q   <= '0;
        end else begin
            init_done_q <= 1'b1;
            push_tag_q  <= push_tag_d;
            pop_tag_q   <= pop_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= push_tag_q;
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (rst)
        !(gnt0 && gnt1));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= FULL_COUNT);

    a_full_blocks: assert property (@(posedge clk) disable iff (rst)
        full |-> (!gnt0 && !gnt1));

    a_fair: assert property (@(posedge clk) disable iff (rst)
        (init_done_q && $past(req0 && req1 && !full) && req0 && req1 && !full)
        |-> (($past(gnt0) && gnt1) || ($past(gnt1) && gnt0)));

    a_tag_order: assert property (@(posedge clk) disable iff (rst)
        (init_done_q && pop) |-> (tag_mem_q[rd_ptr_q] == pop_tag_q));
`endif

endmodule

// File: tb/tb_ring_mem_sched.sv
// tb/tb_ring_mem_sched.sv - scoreboard bench for ring_mem_sched
module tb_ring_mem_sched;

    localparam int W  = 6;
    localparam int DW = 8;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, rd_vld, full, empty;
    logic [DW-1:0] rd_data;
    logic [W:0]    count;

    always #5 clk = ~clk;

    ring_mem_sched #(.WIDTH(W), .DWIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .data0   (data0),
        .gnt0    (gnt0),
        .req1    (req1),
        .data1   (data1),
        .gnt1    (gnt1),
        .rd_req  (rd_req),
        .rd_vld  (rd_vld),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: contents of the ring as a queue, plus arbitration memory.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    int            m_last = 1;
    int            m_wr = 0;
    int            m_rd = 0;
    int            m_pushes = 0;
    int            words_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_vld must match the oldest expected pop, and an expected
    // pop must appear exactly one cycle after it was accepted.
    initial begin : monitor
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_vld) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_rd_vld", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", 32'(rd_data), 32'(e));
                        words_out++;
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rd_vld_missing", 32'd0, 32'd1);
                end
            end
        end
    end

    // One clock cycle: drive at posedge+1, check at negedge, update model after the edge.
    task automatic cycle(input logic r0, input logic [DW-1:0] d0,
                         input logic r1, input logic [DW-1:0] d1, input logic rr);
        logic e0, e1, ep;
        req0 = r0; data0 = d0; req1 = r1; data1 = d1; rd_req = rr;
        e0 = 1'b0;
        e1 = 1'b0;
        if (mq.size() < N) begin
            if (r0 && (!r1 || m_last == 1)) e0 = 1'b1;
            else if (r1) e1 = 1'b1;
        end
        ep = rr && (mq.size() > 0);
        @(negedge clk);
        chk("gnt0", 32'(gnt0), 32'(e0));
        chk("gnt1", 32'(gnt1), 32'(e1));
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == N));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("wr_ptr", 32'(dut.wr_ptr_q), 32'(m_wr));
        chk("rd_ptr", 32'(dut.rd_ptr_q), 32'(m_rd));
        chk("popcount_valid", 32'($countones(dut.valid_q)), 32'(mq.size()));
        @(posedge clk);
        #1;
        if (ep) begin
            exp_q.push_back(mq.pop_front());
            m_rd = (m_rd + 1) % N;
        end
        if (e0 || e1) begin
            mq.push_back(e0 ? d0 : d1);
            m_last = e0 ? 0 : 1;
            m_wr = (m_wr + 1) % N;
            m_pushes++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        mq.delete();
        exp_q.delete();
        m_last = 1; m_wr = 0; m_rd = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (mq.size() > 0 && k < 300) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b1);
            k++;
        end
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        if (mq.size() > 0) chk("drain_timeout", 32'(mq.size()), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k, start_out, start_push;
        #2;
        do_reset();

        // Single writer, three pushes then three pops.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h11, 1'b0, '0, 1'b0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_wr_ptr", 32'(dut.wr_ptr_q), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("t1_empty", 32'(empty), 32'd1);

        // Contention from reset: writer 0 first, then alternating.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
        drain();

        // Fill to full, hold requests while full, pop+push same cycle.
        do_reset();
        k = 0;
        while (mq.size() < N && k < 500) begin
            cycle(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), 8'($urandom), 1'b0);
            k++;
        end
        chk("t3_full", 32'(full), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, '0, 1'b1);
        chk("t3_count_after_swap", 32'(count), 32'd63);
        cycle(1'b1, 8'h66, 1'b0, '0, 1'b0);
        chk("t3_count_refill", 32'(count), 32'd64);
        drain();

        // Pop on empty ignored; same-cycle push visible only next cycle.
        cycle(1'b0, '0, 1'b1, 8'h5C, 1'b1);
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_rd_ptr", 32'(dut.rd_ptr_q), 32'(m_rd));
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);

        // 200 random words through the ring with random back-pressure.
        start_out = words_out;
        start_push = m_pushes;
        k = 0;
        while (((m_pushes - start_push) < 200 || mq.size() > 0) && k < 3000) begin
            cycle(1'((m_pushes - start_push) < 200 && ($urandom % 2) == 1), 8'($urandom),
                  1'((m_pushes - start_push) < 200 && ($urandom % 2) == 1), 8'($urandom),
                  1'(($urandom % 4) != 0));
            k++;
        end
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("t5_words", 32'(words_out - start_out), 32'd200);

        // Reset mid-burst with a pop in flight.
        do_reset();
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("t6_pre_count", 32'(count), 32'd17);
        chk("t6_pre_rd_vld", 32'(rd_vld), 32'd1);
        do_reset();
        cycle(1'b1, 8'hC0, 1'b1, 8'hD0, 1'b0);
        cycle(1'b1, 8'hC1, 1'b1, 8'hD1, 1'b0);
        drain();

        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_mem_sched.md
Name: ring_mem_sched

Overview:
- Schedules a power-of-two ring memory with a per-entry valid bitmap, shared between two write requesters and one read consumer.
- Round-robin arbitration picks one writer per cycle and advances the write pointer. A 1-cycle registered read port drains entries in order.
- Sits in front of the ring datapath in our deep-bug benchmark family. It replaces free-running inc_x/inc_y style pointer control with a real handshake.

Parameters:
- WIDTH, 6, pointer width in bits.
- NUM_ELEMS, 2**WIDTH, ring depth.
- DWIDTH, 8, data word width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  writer 0 requests a push.
- data0  input  DWIDTH  writer 0 payload.
- gnt0  output  1  writer 0 push accepted this cycle.
- req1  input  1  writer 1 requests a push.
- data1  input  DWIDTH  writer 1 payload.
- gnt1  output  1  writer 1 push accepted this cycle.
- rd_req  input  1  consumer requests a pop.
- rd_vld  output  1  rd_data valid, registered.
- rd_data  output  DWIDTH  popped word.
- full  output  1  count == NUM_ELEMS.
- empty  output  1  count == 0.
- count  output  WIDTH+1  number of valid entries.

Behaviour:
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, valid=0, count=0, last_gnt=1 (so writer 0 wins first), rd_vld=0, rd_data=0.
- Memory contents are not reset.
- Grant logic is combinational from req0/req1/last_gnt/full:
  - full=1: gnt0=gnt1=0.
  - Only one writer requesting: that writer is granted.
  - Both requesting: grant the writer != last_gnt.
  - At most one grant per cycle; gnt0 & gnt1 is never 1.
- On a grant: mem[wr_ptr] <= granted data; valid[wr_ptr] <= 1; wr_ptr <= wr_ptr+1, wrapping NUM_ELEMS-1 -> 0; last_gnt <= granted index.
- last_gnt is unchanged on cycles with no grant.
- Pop fires when rd_req & valid[rd_ptr]:
  - rd_data <= mem[rd_ptr]; rd_vld <= 1 next cycle.
  - valid[rd_ptr] <= 0; rd_ptr <= rd_ptr+1 (wraps).
- Otherwise rd_vld <= 0 and rd_data holds its value.
- Read latency is exactly 1 cycle from an accepted rd_req.
- Pop while empty: ignored, no pointer change, rd_vld=0 next cycle.
- Simultaneous push and pop:
  - count unchanged. Permitted when full; the pop frees a slot only next cycle, so a writer is still refused that cycle.
  - When empty, the pushed word is not visible to the same-cycle pop; the earliest pop is the next cycle.
- Pointer collision: wr_ptr == rd_ptr means empty when count==0 and full when count==NUM_ELEMS. Status is always derived from count, never from pointer compare.
- Invariant: count == popcount(valid) at every cycle.
- Reset asserted mid-operation clears all state at once; in-flight rd_vld drops the same cycle.

Optional Feature:
- Macro: RING_SCHED_ASSERT_EN.
- Defined — embedded formal properties are compiled in:
  - gnt0 & gnt1 never both 1.
  - count <= NUM_ELEMS.
  - full -> !gnt0 & !gnt1.
  - Fairness: if req0 & req1 for 2 consecutive non-full cycles, both gnt0 and gnt1 occurred in those cycles.
  - Data integrity: a word pushed with a tag is popped with the same tag, in FIFO order. Checked with a free-running tag counter shadow.
  - Properties are gated by an initstate register so $past is only evaluated after the first cycle.
- Undefined: no assertion logic, identical RTL behaviour.

Decomposition:
- Package ring_sched_pkg holds:
  - Default WIDTH/DWIDTH constants.
  - Typedef for the writer index (1 bit).
  - A grant_t struct {gnt0, gnt1}.
- Sub-module rr_arb2: two-input round-robin arbiter with ports req[1:0], block (from full), gnt[1:0], and an internal last_gnt register. It has its own async reset.
- Ring storage, pointers, valid bitmap and counter stay in ring_mem_sched.

Test Plan:
- Reset then req0=1 only, data0=0x11, 3 cycles -> gnt0=1 each cycle, count=3, wr_ptr=3. Then rd_req for 3 cycles -> rd_vld=1 with 0x11 in each of the 3 following cycles, empty=1.
- req0=req1=1 continuously, data0=0xA0, data1=0xB0, WIDTH=6 -> grants alternate 0,1,0,1 starting with writer 0. Reads return A0,B0,A0,B0.
- Fill to 64 entries -> full=1, gnt0=gnt1=0 while requesting. Then one pop and one push in the same cycle -> push refused, count=63. Next-cycle push accepted, count=64.
- rd_req=1 with empty=1 -> rd_vld=0, rd_ptr unchanged. Same cycle req1=1 -> count=1; pop on the next cycle returns data1.
- Push/pop 200 words through a depth-64 ring -> pointers wrap 3 times and data order is preserved. count == popcount(valid) at every cycle.
- Assert rst mid-burst with count=17 -> count=0, empty=1, rd_vld=0 immediately. After release, the first grant goes to writer 0.
